// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake and data-memory port of the load/store unit.
// master = the load/store unit itself; slave = the pipeline plus data memory.
interface load_store_unit_if;
  logic        LSU_req_valid;
  logic        LSU_req_ready;
  logic        LSU_req_is_store;
  logic [1:0]  LSU_req_length;
  logic        LSU_req_signed;
  logic [31:0] LSU_req_address;
  logic [31:0] LSU_req_wdata;
  logic        LSU_rsp_valid;
  logic        LSU_rsp_ready;
  logic [31:0] LSU_rsp_data;
  logic        LSU_rsp_error;
  logic [1:0]  MEM_read_length;
  logic        MEM_read_signed;
  logic [31:0] MEM_read_address;
  logic [31:0] MEM_read_data;
  logic [1:0]  MEM_write_length;
  logic [31:0] MEM_write_data;
  logic [31:0] MEM_write_address;

  modport master (
    input  LSU_req_valid, LSU_req_is_store, LSU_req_length, LSU_req_signed,
    input  LSU_req_address, LSU_req_wdata, LSU_rsp_ready, MEM_read_data,
    output LSU_req_ready, LSU_rsp_valid, LSU_rsp_data, LSU_rsp_error,
    output MEM_read_length, MEM_read_signed, MEM_read_address,
    output MEM_write_length, MEM_write_data, MEM_write_address
  );

  modport slave (
    output LSU_req_valid, LSU_req_is_store, LSU_req_length, LSU_req_signed,
    output LSU_req_address, LSU_req_wdata, LSU_rsp_ready, MEM_read_data,
    input  LSU_req_ready, LSU_rsp_valid, LSU_rsp_data, LSU_rsp_error,
    input  MEM_read_length, MEM_read_signed, MEM_read_address,
    input  MEM_write_length, MEM_write_data, MEM_write_address
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: registers a request, range/alignment checks it,
// issues one memory access and returns a response, with saturating debug counters.
module load_store_unit #(
  parameter int unsigned MEM_BYTES   = 100,
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  load_store_unit_if.master bus,
  output logic [CNT_W-1:0]  LSU_load_count,
  output logic [CNT_W-1:0]  LSU_store_count,
  output logic [CNT_W-1:0]  LSU_error_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           r_state, w_state_next;
  logic [1:0]       r_len;
  logic             r_signed, r_is_store, r_rsp_error;
  logic [31:0]      r_addr, r_wdata, r_rsp_data;
  logic [CNT_W-1:0] r_load_cnt, r_store_cnt, r_err_cnt;
  logic [2:0]       w_nbytes;
  logic [32:0]      w_end;
  logic             w_misalign, w_req_err, w_accept, w_rsp_hs;

  always_comb begin
    unique case (bus.LSU_req_length)
      2'b01:   w_nbytes = 3'd1;
      2'b10:   w_nbytes = 3'd2;
      2'b11:   w_nbytes = 3'd4;
      default: w_nbytes = 3'd0;
    endcase
  end

  // 33-bit end address so accesses near 2^32 cannot wrap into range.
  assign w_end      = {1'b0, bus.LSU_req_address} + 33'(w_nbytes);
  assign w_misalign = ((bus.LSU_req_length == 2'b10) && bus.LSU_req_address[0]) ||
                      ((bus.LSU_req_length == 2'b11) && (bus.LSU_req_address[1:0] != 2'b00));
  assign w_req_err  = (bus.LSU_req_length == 2'b00) || (w_end > 33'(MEM_BYTES)) ||
                      (ALIGN_CHECK && w_misalign);
  assign w_accept   = (r_state == StIdle) && bus.LSU_req_valid;
  assign w_rsp_hs   = (r_state == StResp) && bus.LSU_rsp_ready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_req_err ? StResp : StIssue;
      StIssue: w_state_next = StResp;
      StResp:  if (bus.LSU_rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) r_state <= StIdle;
    else              r_state <= w_state_next;
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_len       <= 2'b00;
      r_signed    <= 1'b0;
      r_is_store  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_accept) begin
      r_len       <= bus.LSU_req_length;
      r_signed    <= bus.LSU_req_signed;
      r_is_store  <= bus.LSU_req_is_store;
      r_addr      <= bus.LSU_req_address;
      r_wdata     <= bus.LSU_req_wdata;
      r_rsp_data  <= '0;
      r_rsp_error <= w_req_err;
    end else if ((r_state == StIssue) && !r_is_store) begin
      r_rsp_data  <= bus.MEM_read_data;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_rsp_hs) begin
      if (r_rsp_error) begin
        if (~&r_err_cnt) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end else if (r_is_store) begin
        if (~&r_store_cnt) r_store_cnt <= r_store_cnt + CNT_W'(1);
      end else begin
        if (~&r_load_cnt) r_load_cnt <= r_load_cnt + CNT_W'(1);
      end
    end
  end

  // Memory strobes decode from state only, so reset kills a pending write at once.
  always_comb begin
    bus.LSU_req_ready     = (r_state == StIdle);
    bus.LSU_rsp_valid     = (r_state == StResp);
    bus.LSU_rsp_data      = (r_state == StResp) ? r_rsp_data : '0;
    bus.LSU_rsp_error     = (r_state == StResp) && r_rsp_error;
    bus.MEM_read_length   = 2'b00;
    bus.MEM_read_signed   = 1'b0;
    bus.MEM_read_address  = '0;
    bus.MEM_write_length  = 2'b00;
    bus.MEM_write_data    = '0;
    bus.MEM_write_address = '0;
    if (r_state == StIssue) begin
      bus.MEM_read_address  = r_addr;
      bus.MEM_write_address = r_addr;
      if (r_is_store) begin
        bus.MEM_write_length = r_len;
        bus.MEM_write_data   = r_wdata;
      end else begin
        bus.MEM_read_length = r_len;
        bus.MEM_read_signed = r_signed;
      end
    end
  end

  assign LSU_load_count  = r_load_cnt;
  assign LSU_store_count = r_store_cnt;
  assign LSU_error_count = r_err_cnt;

endmodule
